// File: rtl/conv_result_streamer.sv
// conv_result_streamer
// Output end of the 2x2 convolution array. Each rising edge of done_2_2
// captures one frame of four results into a small frame buffer. Buffered
// frames stream out one element per beat on a valid/ready interface, so the
// array can start the next frame before the sink has drained this one.
// All outputs decode directly from flops. out_data is forced to zero while
// no beat is presented, so the outputs are zero in reset.

module conv_result_streamer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done_2_2,
    input  logic [DATA_W-1:0] result11,
    input  logic [DATA_W-1:0] result12,
    input  logic [DATA_W-1:0] result21,
    input  logic [DATA_W-1:0] result22,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_idx,
    output logic              out_last,
    output logic              overflow,
    output logic              busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic              done_d;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [1:0]        elem;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] mem [DEPTH*4];

    logic rise;
    logic xfer;
    logic pop;
    logic full;
    logic push;
    logic drop;

    assign rise = done_2_2 & ~done_d;
    assign xfer = out_valid & out_ready;
    assign pop  = xfer & (elem == 2'd3);
    assign full = (count == FULL_CNT);
    // When full, a pop on the same edge frees exactly the slot wr_ptr points
    // at. That slot's last beat is accepted on this edge, so overwriting it
    // here is safe.
    assign push = rise & (~full | pop);
    assign drop = rise & full & ~pop;

    // Control state: edge detect, pointers, occupancy, sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_d   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            elem     <= 2'd0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            done_d <= done_2_2;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (xfer) begin
                elem <= elem + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Frame storage. The frame data needs no reset because out_data is masked
    // by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[{wr_ptr, 2'd0}] <= result11;
            mem[{wr_ptr, 2'd1}] <= result12;
            mem[{wr_ptr, 2'd2}] <= result21;
            mem[{wr_ptr, 2'd3}] <= result22;
        end
    end

    assign out_valid = (count != '0);
    assign busy      = out_valid;
    assign out_idx   = elem;
    assign out_last  = out_valid & (elem == 2'd3);
    assign out_data  = out_valid ? mem[{rd_ptr, elem}] : '0;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Bench for conv_result_streamer. Stimulus pushes the expected beats of each
// accepted frame into a queue. A monitor pops the queue and compares on every
// accepted beat.

module tb_conv_result_streamer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       done_2_2 = 1'b0;
    logic [7:0] result11 = '0;
    logic [7:0] result12 = '0;
    logic [7:0] result21 = '0;
    logic [7:0] result22 = '0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] out_idx;
    logic       out_last;
    logic       overflow;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];

    conv_result_streamer #(.DATA_W(8), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .done_2_2(done_2_2),
        .result11(result11), .result12(result12),
        .result21(result21), .result22(result22),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_last(out_last),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " outputs"}, {out_data, out_valid, out_idx, out_last, overflow, busy}, 0);
    endtask

    // Presents one frame with done_2_2 high and moves past the capture edge.
    // done_2_2 is left high. The result inputs are scrambled afterwards, so
    // sampling outside the capture edge would show up as bad data.
    task automatic frame(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d, input bit accepted);
        result11 = a; result12 = b; result21 = c; result22 = d;
        done_2_2 = 1'b1;
        if (accepted) begin
            exp_q.push_back({a, 2'd0, 1'b0});
            exp_q.push_back({b, 2'd1, 1'b0});
            exp_q.push_back({c, 2'd2, 1'b0});
            exp_q.push_back({d, 2'd3, 1'b1});
        end
        tick();
        result11 = 8'($urandom); result12 = 8'($urandom);
        result21 = 8'($urandom); result22 = 8'($urandom);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            tick();
            n++;
        end
        chk({name, " drain_left"}, exp_q.size(), 0);
        chk({name, " drain_valid"}, out_valid, 0);
    endtask

    // Monitor: sample at the falling edge, then compare the beat the next
    // rising edge will accept.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {out_data, out_idx, out_last}, 11'h7ff);
            end else begin
                chk("beat", {out_data, out_idx, out_last}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // 1 reset
        #12;
        chk_all_zero("reset_hold");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) tick();
        chk_all_zero("after_release");

        // 2 single frame, done held high
        out_ready = 1'b1;
        chk("t2_pre_valid", out_valid, 0);
        frame(8'd12, 8'd10, 8'd9, 8'd10, 1'b1);
        chk("t2_latency_valid", out_valid, 1);
        drain("t2");
        repeat (4) tick();
        chk("t2_no_recapture", busy, 0);
        done_2_2 = 1'b0;
        tick();

        // 3 backpressure
        out_ready = 1'b0;
        frame(8'd12, 8'd10, 8'd9, 8'd10, 1'b1);
        done_2_2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold", {out_valid, out_data, out_idx, out_last}, {1'b1, 8'd12, 2'd0, 1'b0});
            tick();
        end
        out_ready = 1'b1;
        drain("t3");

        // 4 overflow
        out_ready = 1'b0;
        frame(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
        done_2_2 = 1'b0; tick();
        frame(8'd5, 8'd6, 8'd7, 8'd8, 1'b1);
        done_2_2 = 1'b0; tick();
        chk("t4_no_overflow_yet", overflow, 0);
        frame(8'd9, 8'd10, 8'd11, 8'd12, 1'b0);
        done_2_2 = 1'b0; tick();
        chk("t4_overflow", overflow, 1);
        out_ready = 1'b1;
        drain("t4");
        repeat (3) tick();
        chk("t4_overflow_sticky", overflow, 1);
        rst = 1'b1;
        #1;
        chk("t4_overflow_cleared", overflow, 0);
        tick();
        rst = 1'b0;
        tick();

        // 5 full + pop collision
        out_ready = 1'b0;
        frame(8'd41, 8'd42, 8'd43, 8'd44, 1'b1);
        done_2_2 = 1'b0; tick();
        frame(8'd51, 8'd52, 8'd53, 8'd54, 1'b1);
        done_2_2 = 1'b0; tick();
        out_ready = 1'b1;
        repeat (3) tick();
        chk("t5_on_last_beat", {out_idx, out_data}, {2'd3, 8'd44});
        frame(8'd61, 8'd62, 8'd63, 8'd64, 1'b1);
        done_2_2 = 1'b0;
        chk("t5_no_overflow", overflow, 0);
        chk("t5_next_frame_first", {out_idx, out_data}, {2'd0, 8'd51});
        drain("t5");
        chk("t5_overflow_final", overflow, 0);

        // 6 reset mid-stream
        out_ready = 1'b1;
        frame(8'd21, 8'd22, 8'd23, 8'd24, 1'b1);
        done_2_2 = 1'b0;
        tick();
        tick();
        chk("t6_before_reset_idx", out_idx, 2);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk_all_zero("t6_async_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) tick();
        chk("t6_no_stale", {out_valid, busy}, 0);
        frame(8'd31, 8'd32, 8'd33, 8'd34, 1'b1);
        done_2_2 = 1'b0;
        chk("t6_restart_idx", out_idx, 0);
        drain("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
